// File: rtl/demux14_reg.sv
// Registered 1-to-4 demultiplexer with two independent decode paths (gate-level and
// conditional) that are cross-checked every valid cycle into a sticky mismatch flag.
module demux14_reg #(
  parameter int unsigned DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     d,
  input  logic [1:0]            s,
  output logic [4*DATA_W-1:0]   y,
  output logic                  out_valid,
  output logic                  mismatch
);

  logic [4*DATA_W-1:0] gate_y;
  logic [4*DATA_W-1:0] cond_y;
  logic [4*DATA_W-1:0] y_q, y_d;
  logic                out_valid_q, out_valid_d;
  logic                mismatch_q, mismatch_d;

  // Gate-level decode: each select minterm is replicated across the lane width.
  always_comb begin
    gate_y = '0;
    gate_y[0*DATA_W +: DATA_W] = d & {DATA_W{~s[1] & ~s[0]}};
    gate_y[1*DATA_W +: DATA_W] = d & {DATA_W{~s[1] &  s[0]}};
    gate_y[2*DATA_W +: DATA_W] = d & {DATA_W{ s[1] & ~s[0]}};
    gate_y[3*DATA_W +: DATA_W] = d & {DATA_W{ s[1] &  s[0]}};
  end

  // Conditional decode: an unknown select falls to the default and drives all lanes low.
  always_comb begin
    cond_y = '0;
    case (s)
      2'b00:   cond_y[0*DATA_W +: DATA_W] = d;
      2'b01:   cond_y[1*DATA_W +: DATA_W] = d;
      2'b10:   cond_y[2*DATA_W +: DATA_W] = d;
      2'b11:   cond_y[3*DATA_W +: DATA_W] = d;
      default: cond_y = '0;
    endcase
  end

  always_comb begin
    y_d         = in_valid ? cond_y : '0;
    out_valid_d = in_valid;
    mismatch_d  = mismatch_q | (in_valid & (gate_y !== cond_y));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_demux14_reg.sv
// Directed bench for demux14_reg: a 1-bit instance for routing/gating/mismatch checks and an
// 8-bit instance for wide-lane placement.
module tb_demux14_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        d;
  logic [1:0]  s;
  logic [3:0]  y;
  logic        out_valid;
  logic        mismatch;

  logic [7:0]  d8;
  logic [1:0]  s8;
  logic [31:0] y8;
  logic        out_valid8;
  logic        mismatch8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux14_reg #(.DATA_W(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .d         (d),
    .s         (s),
    .y         (y),
    .out_valid (out_valid),
    .mismatch  (mismatch)
  );

  demux14_reg #(.DATA_W(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .d         (d8),
    .s         (s8),
    .y         (y8),
    .out_valid (out_valid8),
    .mismatch  (mismatch8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; d = 1'b1; s = 2'b11;
    d8 = 8'hA5; s8 = 2'b10;

    // Reset held for two edges with a live sample on the inputs.
    tick();
    check("rst1_y", {28'd0, y}, 32'h0);
    check("rst1_ov", {31'd0, out_valid}, 32'h0);
    check("rst1_mm", {31'd0, mismatch}, 32'h0);
    tick();
    check("rst2_y", {28'd0, y}, 32'h0);
    check("rst2_ov", {31'd0, out_valid}, 32'h0);
    check("rst2_mm", {31'd0, mismatch}, 32'h0);
    check("rst2_y8", y8, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_y", {28'd0, y}, 32'h8);
    check("post_rst_ov", {31'd0, out_valid}, 32'h1);
    check("wide_lane2", y8, 32'h00A5_0000);
    check("wide_ov", {31'd0, out_valid8}, 32'h1);

    s8 = 2'b11;
    d8 = 8'h3C;
    // Exhaustive {d,s} sweep on the 1-bit instance.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      d = v[2];
      s = v[1:0];
      tick();
      check($sformatf("sweep%0d_y", i), {28'd0, y}, (i < 4) ? 32'h0 : (32'h1 << (i - 4)));
      check($sformatf("sweep%0d_mm", i), {31'd0, mismatch}, 32'h0);
      if (i == 0) check("wide_lane3", y8, 32'h3C00_0000);
    end

    // Valid gating.
    d = 1'b1; s = 2'b10;
    in_valid = 1'b1; tick();
    check("vg1_y", {28'd0, y}, 32'h4);
    check("vg1_ov", {31'd0, out_valid}, 32'h1);
    in_valid = 1'b0; tick();
    check("vg0_y", {28'd0, y}, 32'h0);
    check("vg0_ov", {31'd0, out_valid}, 32'h0);
    check("vg0_y8", y8, 32'h0);
    in_valid = 1'b1; tick();
    check("vg2_y", {28'd0, y}, 32'h4);
    check("vg2_ov", {31'd0, out_valid}, 32'h1);

    // Back-to-back select changes, no bubbles.
    s = 2'b00; tick();
    check("b2b0_y", {28'd0, y}, 32'h1);
    s = 2'b11; tick();
    check("b2b1_y", {28'd0, y}, 32'h8);
    check("b2b1_ov", {31'd0, out_valid}, 32'h1);
    s = 2'b01; tick();
    check("b2b2_y", {28'd0, y}, 32'h2);

    // Corrupt the gate-level path for one edge; mismatch must set and stick.
    s = 2'b00;
    force u_dut1.gate_y = 4'b0000;
    tick();
    release u_dut1.gate_y;
    check("mm_set", {31'd0, mismatch}, 32'h1);
    check("mm_y", {28'd0, y}, 32'h1);
    s = 2'b10; tick();
    check("mm_hold1", {31'd0, mismatch}, 32'h1);
    in_valid = 1'b0; tick();
    check("mm_hold2", {31'd0, mismatch}, 32'h1);
    check("mm8_clean", {31'd0, mismatch8}, 32'h0);
    rst = 1'b1; tick();
    check("mm_clr", {31'd0, mismatch}, 32'h0);
    check("mm_clr_y", {28'd0, y}, 32'h0);
    rst = 1'b0; in_valid = 1'b1; d = 1'b1; s = 2'b01; tick();
    check("final_y", {28'd0, y}, 32'h2);
    check("final_mm", {31'd0, mismatch}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
